// File: rtl/bin2bcd_if.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_if
// Description : Valid/ready handshake bundle for the sequential binary-to-BCD
//               converter. Upstream word in, packed BCD result plus overflow
//               flag out.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  // Converter side
  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, ovf
  );

  // Producer/consumer side
  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, ovf
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter. One binary bit is shifted
//               into the BCD accumulator per clock; digits >= 5 are corrected
//               by +3 before each shift. Overflow collects every bit pushed
//               out of the top digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    shreg;
  logic [BCD_W-1:0]    acc;
  logic [BCD_W-1:0]    acc_corr;
  logic                ovf_q;
  logic [CNT_W-1:0]    cnt;

  // Add-3 correction of every digit in parallel. 4-bit arithmetic is enough:
  // a digit is at most 9 here, so the corrected value never exceeds 12.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign acc_corr[4*k +: 4] = (acc[4*k +: 4] >= 4'd5) ? (acc[4*k +: 4] + 4'd3)
                                                           : acc[4*k +: 4];
    end
  endgenerate

  // Control FSM and datapath: load on acceptance, shift WIDTH times, hold
  // the result until the downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg <= bus.bin_in;
            acc   <= '0;
            ovf_q <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Bit leaving the top digit means the value needs another digit.
          acc   <= {acc_corr[BCD_W-2:0], shreg[WIDTH-1]};
          ovf_q <= ovf_q | acc_corr[BCD_W-1];
          shreg <= shreg << 1;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from state: no input-to-output paths.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.bcd_out   = acc;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire
